// File: rtl/i2c_slave_responder_if.sv
// Bus-side and register-write signals of the I2C target, bundled for port hookup.
// wr_stb is a one-cycle valid with no ready: the bank write is never back-pressured.
interface i2c_slave_responder_if #(
    parameter int DEPTH_LOG2 = 6
);
    logic                  scl_in;
    logic                  sda_in;
    logic                  sda_oe;
    logic                  busy;
    logic                  wr_stb;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [7:0]            wr_data;

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe,
        output busy,
        output wr_stb,
        output wr_addr,
        output wr_data
    );

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe,
        input  busy,
        input  wr_stb,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target with a 2**DEPTH_LOG2 x 8 register bank, oversampled in clk_50.
// dbg_state exposes the FSM: 0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 REG, 4 REG_ACK, 5 WDATA, 6 WDATA_ACK, 7 RDATA, 8 RACK, 9 WAIT_STOP.
module i2c_slave_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'b1101000,
    parameter int         DEPTH_LOG2 = 6
) (
    input  logic                 clk_50,
    input  logic                 state_reset,
    i2c_slave_responder_if.slave bus,
    output logic [3:0]           dbg_state
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RACK      = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [7:0]            shift, shift_n;
    logic [7:0]            tx, tx_n;
    logic [DEPTH_LOG2-1:0] ptr, ptr_n;
    logic                  rw, rw_n;
    logic                  ack, ack_n;
    logic                  sda_oe, sda_oe_n;
    logic                  busy, busy_n;
    logic                  wr_stb, wr_stb_n;
    logic [DEPTH_LOG2-1:0] wr_addr, wr_addr_n;
    logic [7:0]            wr_data, wr_data_n;
    logic                  bank_we;
    logic [7:0]            bank [DEPTH];

    // Sync chains carry no reset so a reset pulse mid-transfer cannot fake a bus edge.
    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    always_ff @(posedge clk_50) begin
        scl_s1 <= bus.scl_in;
        scl_s2 <= scl_s1;
        scl_h  <= scl_s2;
        sda_s1 <= bus.sda_in;
        sda_s2 <= sda_s1;
        sda_h  <= sda_s2;
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = ~sda_s2 & sda_h & scl_s2 & scl_h;
    assign stop_det  = sda_s2 & ~sda_h & scl_s2 & scl_h;

    always_ff @(posedge clk_50) begin
        if (!state_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            tx      <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            ack     <= 1'b1;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            tx      <= tx_n;
            ptr     <= ptr_n;
            rw      <= rw_n;
            ack     <= ack_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            wr_stb  <= wr_stb_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            if (bank_we) bank[ptr] <= shift;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = shift;
        tx_n      = tx;
        ptr_n     = ptr;
        rw_n      = rw;
        ack_n     = ack;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        bank_we   = 1'b0;

        if (stop_det) begin
            state_n  = IDLE;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            shift_n = '0;
        end else begin
            unique case (state)
                IDLE: ;
                WAIT_STOP: sda_oe_n = 1'b0;
                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s2};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        if (state == ADDR) begin
                            if (shift[7:1] == DEV_ADDR) begin
                                busy_n   = 1'b1;
                                sda_oe_n = 1'b1;
                                rw_n     = shift[0];
                                state_n  = ADDR_ACK;
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = WAIT_STOP;
                            end
                        end else if (state == REG) begin
                            ptr_n    = shift[DEPTH_LOG2-1:0];
                            sda_oe_n = 1'b1;
                            state_n  = REG_ACK;
                        end else begin
                            bank_we   = 1'b1;
                            wr_stb_n  = 1'b1;
                            wr_addr_n = ptr;
                            wr_data_n = shift;
                            ptr_n     = ptr + DEPTH_LOG2'(1);
                            sda_oe_n  = 1'b1;
                            state_n   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd9) begin
                        cnt_n    = '0;
                        sda_oe_n = 1'b0;
                        if (state == ADDR_ACK && rw) begin
                            tx_n     = bank[ptr];
                            sda_oe_n = ~bank[ptr][7];
                            state_n  = RDATA;
                        end else if (state == ADDR_ACK) begin
                            state_n = REG;
                        end else begin
                            state_n = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            ptr_n    = ptr + DEPTH_LOG2'(1);
                            state_n  = RACK;
                        end else begin
                            sda_oe_n = ~tx[6];
                            tx_n     = {tx[6:0], 1'b0};
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                        ack_n = sda_s2;
                    end else if (scl_fall && cnt == 4'd9) begin
                        cnt_n = '0;
                        if (!ack) begin
                            tx_n     = bank[ptr];
                            sda_oe_n = ~bank[ptr][7];
                            state_n  = RDATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = WAIT_STOP;
                        end
                    end
                end
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe  = sda_oe;
    assign bus.busy    = busy;
    assign bus.wr_stb  = wr_stb;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign dbg_state   = state;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master, vector table of write
// transactions, hand-written read/abort/reset sequences and a wr_stb scoreboard.
module tb_i2c_slave_responder;
    localparam int DL = 6;
    localparam logic [3:0] S_IDLE = 4'd0, S_WAIT_STOP = 4'd9;

    logic       clk_50 = 1'b0;
    logic       state_reset = 1'b0;
    logic [3:0] dbg_state;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    int         checks = 0;
    int         failures = 0;
    logic [13:0] exp_q[$];
    logic       oe_guard = 1'b0;
    int         oe_viol = 0;

    i2c_slave_responder_if #(.DEPTH_LOG2(DL)) bus();

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_slave_responder #(.DEV_ADDR(7'b1101000), .DEPTH_LOG2(DL)) dut (
        .clk_50      (clk_50),
        .state_reset (state_reset),
        .bus         (bus.slave),
        .dbg_state   (dbg_state)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for bank writes
    always @(negedge clk_50) begin
        if (oe_guard && bus.sda_oe) oe_viol++;
        if (state_reset && bus.wr_stb) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected actual=0x%0h required=none", {bus.wr_addr, bus.wr_data});
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== e) begin
                    failures++;
                    $display("FAIL wr_stb actual=0x%0h required=0x%0h", {bus.wr_addr, bus.wr_data}, e);
                end
            end
        end
    end

    initial begin
        #5ms;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic q();
        repeat (8) @(posedge clk_50);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic clock_bit(input logic b, output logic got);
        sda_m = b; q();
        scl_m = 1'b1; q();
        got = bus.sda_in; q();
        scl_m = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_bus);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
        clock_bit(1'b1, ack_bus);
    endtask

    task automatic read_byte(input logic m_ack_bus, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(m_ack_bus, dummy);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] reg_byte;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nd;
        logic       exp_ack;   // bus level seen in each 9th clock: 0 = target ACK
        logic       exp_busy;
    } wvec_t;

    task automatic run_wvec(input wvec_t v, input string tag);
        logic       a;
        logic [5:0] p;
        logic [7:0] dat;
        oe_guard = v.exp_ack;
        oe_viol  = 0;
        i2c_start();
        write_byte(v.addr_byte, a);
        chk({tag, ".addr_ack"}, a, v.exp_ack);
        chk({tag, ".busy"}, bus.busy, v.exp_busy);
        write_byte(v.reg_byte, a);
        chk({tag, ".reg_ack"}, a, v.exp_ack);
        p = v.reg_byte[5:0];
        for (int k = 0; k < v.nd; k++) begin
            dat = (k == 0) ? v.d0 : v.d1;
            if (!v.exp_ack) exp_q.push_back({p, dat});
            write_byte(dat, a);
            chk($sformatf("%s.data%0d_ack", tag, k), a, v.exp_ack);
            p = p + 6'd1;
        end
        i2c_stop();
        chk({tag, ".busy_after_stop"}, bus.busy, 1'b0);
        chk({tag, ".idle_after_stop"}, dbg_state, S_IDLE);
        if (v.exp_ack) chk({tag, ".no_sda_oe"}, oe_viol, 0);
        oe_guard = 1'b0;
    endtask

    wvec_t vecs [4];
    wvec_t tail;

    initial begin
        logic       a;
        logic [7:0] d;
        logic       dummy;

        vecs[0] = '{addr_byte: 8'hD0, reg_byte: 8'h38, d0: 8'hF0, d1: 8'h00, nd: 1, exp_ack: 1'b0, exp_busy: 1'b1};
        vecs[1] = '{addr_byte: 8'hA0, reg_byte: 8'h12, d0: 8'h00, d1: 8'h00, nd: 0, exp_ack: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{addr_byte: 8'hD0, reg_byte: 8'h3F, d0: 8'h11, d1: 8'h22, nd: 2, exp_ack: 1'b0, exp_busy: 1'b1};
        vecs[3] = '{addr_byte: 8'hD0, reg_byte: 8'h39, d0: 8'h5A, d1: 8'h00, nd: 1, exp_ack: 1'b0, exp_busy: 1'b1};
        tail    = '{addr_byte: 8'hD0, reg_byte: 8'h20, d0: 8'h77, d1: 8'h00, nd: 1, exp_ack: 1'b0, exp_busy: 1'b1};

        // Clock/reset
        repeat (5) @(posedge clk_50);
        @(negedge clk_50);
        chk("rst.sda_oe", bus.sda_oe, 1'b0);
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.wr_stb", bus.wr_stb, 1'b0);
        chk("rst.wr_addr", bus.wr_addr, 6'h00);
        chk("rst.wr_data", bus.wr_data, 8'h00);
        chk("rst.state", dbg_state, S_IDLE);
        @(posedge clk_50); #1;
        state_reset = 1'b1;
        q();

        for (int i = 0; i < 4; i++) run_wvec(vecs[i], $sformatf("vec%0d", i));

        // Random read: pointer 0x38, repeated START, two bytes
        i2c_start();
        write_byte(8'hD0, a); chk("rd.addr_w_ack", a, 1'b0);
        write_byte(8'h38, a); chk("rd.reg_ack", a, 1'b0);
        i2c_start();
        write_byte(8'hD1, a); chk("rd.addr_r_ack", a, 1'b0);
        chk("rd.busy", bus.busy, 1'b1);
        read_byte(1'b0, d); chk("rd.byte0", d, 8'hF0);
        read_byte(1'b1, d); chk("rd.byte1", d, 8'h5A);
        chk("rd.released_after_nack", bus.sda_oe, 1'b0);
        chk("rd.wait_stop", dbg_state, S_WAIT_STOP);
        i2c_stop();
        chk("rd.idle", dbg_state, S_IDLE);
        chk("rd.busy_after_stop", bus.busy, 1'b0);

        // Abort: STOP after 4 data bits
        i2c_start();
        write_byte(8'hD0, a); chk("ab.addr_ack", a, 1'b0);
        write_byte(8'h20, a); chk("ab.reg_ack", a, 1'b0);
        clock_bit(1'b1, dummy); clock_bit(1'b0, dummy);
        clock_bit(1'b1, dummy); clock_bit(1'b0, dummy);
        i2c_stop();
        chk("ab.sda_oe", bus.sda_oe, 1'b0);
        chk("ab.idle", dbg_state, S_IDLE);
        chk("ab.busy", bus.busy, 1'b0);
        run_wvec(tail, "ab_follow");

        // Reset during the 5th bit of a data byte
        i2c_start();
        write_byte(8'hD0, a); chk("rs.addr_ack", a, 1'b0);
        write_byte(8'h38, a); chk("rs.reg_ack", a, 1'b0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, dummy);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        @(posedge clk_50); #1; state_reset = 1'b0;
        @(posedge clk_50); #1; state_reset = 1'b1;
        @(negedge clk_50);
        chk("rs.sda_oe", bus.sda_oe, 1'b0);
        chk("rs.busy", bus.busy, 1'b0);
        chk("rs.idle", dbg_state, S_IDLE);
        #1; q();
        scl_m = 1'b0; q();
        for (int i = 0; i < 3; i++) clock_bit(1'b0, dummy);
        clock_bit(1'b1, a); chk("rs.ignored_no_ack", a, 1'b1);
        chk("rs.still_idle", dbg_state, S_IDLE);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, a); chk("rs.rb_addr_ack", a, 1'b0);
        write_byte(8'h38, a); chk("rs.rb_reg_ack", a, 1'b0);
        i2c_start();
        write_byte(8'hD1, a); chk("rs.rb_addr_r_ack", a, 1'b0);
        read_byte(1'b1, d); chk("rs.bank_cleared", d, 8'h00);
        i2c_stop();

        q();
        chk("sb.queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
